// File: rtl/issue_unit_if.sv
// Interface bundle for the Tomasulo issue stage.
// Groups the decoder handshake, the reservation-station release and CDB
// inputs, and the registered issue packet going to the reservation stations.
//   slave  : the issue unit side (consumes decoder/release/CDB, drives issue)
//   master : the environment side (decoder, RS release logic, CDB)
// Signals:
//   in_valid/in_ready        decoder handshake
//   in_inactive, in_mem, in_mul, in_lw_sw, in_rs1, in_rs2, in_rd  decoded fields
//   rs_release_valid/tag     reservation slot freed this cycle
//   cdb_valid/cdb_tag        common data bus broadcast
//   iss_*                    registered issue packet, iss_valid is a 1-cycle pulse
//   stall_cnt                saturating count of stalled cycles
interface issue_unit_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_inactive;
  logic             in_mem;
  logic             in_mul;
  logic             in_lw_sw;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [4:0]       in_rd;
  logic             rs_release_valid;
  logic [TAG_W-1:0] rs_release_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;
  logic [1:0]       iss_class;
  logic             iss_lw_sw;
  logic [4:0]       iss_rs1;
  logic [4:0]       iss_rs2;
  logic [4:0]       iss_rd;
  logic [TAG_W-1:0] iss_q1;
  logic [TAG_W-1:0] iss_q2;
  logic             iss_has_rd;
  logic [15:0]      stall_cnt;

  modport slave (
    input  in_valid, in_inactive, in_mem, in_mul, in_lw_sw,
           in_rs1, in_rs2, in_rd,
           rs_release_valid, rs_release_tag, cdb_valid, cdb_tag,
    output in_ready, iss_valid, iss_tag, iss_class, iss_lw_sw,
           iss_rs1, iss_rs2, iss_rd, iss_q1, iss_q2, iss_has_rd, stall_cnt
  );

  modport master (
    output in_valid, in_inactive, in_mem, in_mul, in_lw_sw,
           in_rs1, in_rs2, in_rd,
           rs_release_valid, rs_release_tag, cdb_valid, cdb_tag,
    input  in_ready, iss_valid, iss_tag, iss_class, iss_lw_sw,
           iss_rs1, iss_rs2, iss_rd, iss_q1, iss_q2, iss_has_rd, stall_cnt
  );
endinterface

// File: rtl/issue_unit.sv
// Tomasulo issue stage.
// Holds one decoded instruction, allocates the lowest free reservation slot
// of its class (ALU / MUL / MEM), renames rs1/rs2 through a 32-entry
// register status table (RST) with CDB bypass, and emits a registered issue
// packet. The decoder is stalled while the held instruction's class is full.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : issue_unit_if.slave (decoder handshake, release, CDB, issue packet)
module issue_unit #(
  parameter int NUM_ALU_RS = 3,
  parameter int NUM_MUL_RS = 2,
  parameter int NUM_MEM_RS = 3,
  parameter int TAG_W      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  issue_unit_if.slave  bus
);

  localparam int NUM_RS   = NUM_ALU_RS + NUM_MUL_RS + NUM_MEM_RS;
  localparam int MUL_BASE = NUM_ALU_RS;
  localparam int MEM_BASE = NUM_ALU_RS + NUM_MUL_RS;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;

  typedef enum logic {S_EMPTY, S_HELD} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Source renaming: x0 never has a producer, and a tag broadcast on the
  // CDB in the issuing cycle is already resolved.
  function automatic logic [TAG_W-1:0] rename_src(
    input logic [4:0]       idx,
    input logic [TAG_W-1:0] tag,
    input logic             cdb_v,
    input logic [TAG_W-1:0] cdb_t
  );
    if (idx == 5'd0)             return '0;
    if (cdb_v && (cdb_t == tag)) return '0;
    return tag;
  endfunction

  state_t           r_state;
  logic [NUM_RS-1:0] r_busy;
  logic [TAG_W-1:0] r_rst [32];
  logic [15:0]      r_stall_cnt;

  logic [1:0]       r_h_cls;
  logic             r_h_lw_sw;
  logic [4:0]       r_h_rs1;
  logic [4:0]       r_h_rs2;
  logic [4:0]       r_h_rd;

  logic             r_iss_valid;
  logic [TAG_W-1:0] r_iss_tag;
  logic [1:0]       r_iss_class;
  logic             r_iss_lw_sw;
  logic [4:0]       r_iss_rs1;
  logic [4:0]       r_iss_rs2;
  logic [4:0]       r_iss_rd;
  logic [TAG_W-1:0] r_iss_q1;
  logic [TAG_W-1:0] r_iss_q2;
  logic             r_iss_has_rd;

  int               w_base;
  int               w_cnt;
  logic             w_found;
  logic [TAG_W-1:0] w_alloc_tag;
  logic [NUM_RS-1:0] w_alloc_mask;
  logic [NUM_RS-1:0] w_rel_mask;
  logic             w_issue_now;
  logic             w_accept;
  logic             w_is_load;
  logic             w_has_rd;
  logic [TAG_W-1:0] w_q1;
  logic [TAG_W-1:0] w_q2;
  logic [1:0]       w_in_cls;

  // Slot range of the held instruction's class
  always_comb begin
    w_base = 0;
    w_cnt  = NUM_ALU_RS;
    case (r_h_cls)
      CLS_MUL: begin w_base = MUL_BASE; w_cnt = NUM_MUL_RS; end
      CLS_MEM: begin w_base = MEM_BASE; w_cnt = NUM_MEM_RS; end
      default: ;
    endcase
  end

  // Lowest free slot: scan downward so the lowest index is written last.
  // Uses the busy bitmap before this cycle's release.
  always_comb begin
    w_found      = 1'b0;
    w_alloc_tag  = '0;
    w_alloc_mask = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if ((i >= w_base) && (i < w_base + w_cnt) && !r_busy[i]) begin
        w_found      = 1'b1;
        w_alloc_tag  = TAG_W'(i + 1);
        w_alloc_mask = '0;
        w_alloc_mask[i] = 1'b1;
      end
    end
  end

  // Release decode; tag 0 and out-of-range tags match no slot
  always_comb begin
    w_rel_mask = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (bus.rs_release_valid && (bus.rs_release_tag == TAG_W'(i + 1)))
        w_rel_mask[i] = 1'b1;
    end
  end

  assign w_issue_now  = (r_state == S_HELD) && w_found;
  assign bus.in_ready = (r_state == S_EMPTY) || w_issue_now;
  assign w_accept     = bus.in_valid && bus.in_ready && !bus.in_inactive;
  assign w_in_cls     = bus.in_mem ? CLS_MEM : (bus.in_mul ? CLS_MUL : CLS_ALU);

  assign w_is_load = (r_h_cls == CLS_MEM) && r_h_lw_sw;
  assign w_has_rd  = !((r_h_cls == CLS_MEM) && !r_h_lw_sw) && (r_h_rd != 5'd0);
  assign w_q1      = rename_src(r_h_rs1, r_rst[r_h_rs1], bus.cdb_valid, bus.cdb_tag);
  assign w_q2      = w_is_load ? '0
                               : rename_src(r_h_rs2, r_rst[r_h_rs2], bus.cdb_valid, bus.cdb_tag);

  // Control state: FSM, busy bitmap, RST, issue packet, stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_busy       <= '0;
      r_stall_cnt  <= '0;
      for (int i = 0; i < 32; i++) r_rst[i] <= '0;
      r_iss_valid  <= 1'b0;
      r_iss_tag    <= '0;
      r_iss_class  <= '0;
      r_iss_lw_sw  <= 1'b0;
      r_iss_rs1    <= '0;
      r_iss_rs2    <= '0;
      r_iss_rd     <= '0;
      r_iss_q1     <= '0;
      r_iss_q2     <= '0;
      r_iss_has_rd <= 1'b0;
    end else begin
      r_busy      <= (r_busy & ~w_rel_mask) | (w_issue_now ? w_alloc_mask : '0);
      r_iss_valid <= w_issue_now;

      // CDB clear first; the issue write below overrides it for rd
      for (int i = 0; i < 32; i++) begin
        if (bus.cdb_valid && (r_rst[i] == bus.cdb_tag)) r_rst[i] <= '0;
      end

      if (w_issue_now) begin
        if (w_has_rd) r_rst[r_h_rd] <= w_alloc_tag;
        r_iss_tag    <= w_alloc_tag;
        r_iss_class  <= r_h_cls;
        r_iss_lw_sw  <= r_h_lw_sw && (r_h_cls == CLS_MEM);
        r_iss_rs1    <= r_h_rs1;
        r_iss_rs2    <= r_h_rs2;
        r_iss_rd     <= r_h_rd;
        r_iss_q1     <= w_q1;
        r_iss_q2     <= w_q2;
        r_iss_has_rd <= w_has_rd;
      end

      case (r_state)
        S_EMPTY: if (w_accept) r_state <= S_HELD;
        S_HELD: begin
          if (w_issue_now) r_state <= w_accept ? S_HELD : S_EMPTY;
          else             r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Holding register data; validity is tracked by r_state alone
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_h_cls   <= w_in_cls;
      r_h_lw_sw <= bus.in_lw_sw;
      r_h_rs1   <= bus.in_rs1;
      r_h_rs2   <= bus.in_rs2;
      r_h_rd    <= bus.in_rd;
    end
  end

  assign bus.iss_valid  = r_iss_valid;
  assign bus.iss_tag    = r_iss_tag;
  assign bus.iss_class  = r_iss_class;
  assign bus.iss_lw_sw  = r_iss_lw_sw;
  assign bus.iss_rs1    = r_iss_rs1;
  assign bus.iss_rs2    = r_iss_rs2;
  assign bus.iss_rd     = r_iss_rd;
  assign bus.iss_q1     = r_iss_q1;
  assign bus.iss_q2     = r_iss_q2;
  assign bus.iss_has_rd = r_iss_has_rd;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_issue_unit.sv
// Testbench for issue_unit: directed instruction stream with hand-computed
// issue packets pushed to a scoreboard queue; a negedge monitor pops and
// compares every issue pulse. Direct checks cover reset, latency, stalls.
module tb_issue_unit;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_unit_if #(.TAG_W(TAG_W)) bus ();

  issue_unit #(
    .NUM_ALU_RS(3), .NUM_MUL_RS(2), .NUM_MEM_RS(3), .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] tag;
    logic [1:0] cls;
    logic       lw_sw;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] q1;
    logic [3:0] q2;
    logic       has_rd;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t mon_act;
  pkt_t mon_exp;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_pkt(input logic [3:0] tag, input logic [1:0] cls, input logic lw,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [3:0] q1, input logic [3:0] q2, input logic has_rd);
    pkt_t p;
    p = '{tag: tag, cls: cls, lw_sw: lw, rs1: r1, rs2: r2, rd: rd, q1: q1, q2: q2, has_rd: has_rd};
    exp_q.push_back(p);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic inact, input logic mem, input logic mul, input logic lw,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    int budget;
    budget = 100;
    bus.in_valid    = 1'b1;
    bus.in_inactive = inact;
    bus.in_mem      = mem;
    bus.in_mul      = mul;
    bus.in_lw_sw    = lw;
    bus.in_rs1      = r1;
    bus.in_rs2      = r2;
    bus.in_rd       = rd;
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready %b, required 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.iss_valid === 1'b1) begin
      mon_act = '{tag: bus.iss_tag, cls: bus.iss_class, lw_sw: bus.iss_lw_sw,
                  rs1: bus.iss_rs1, rs2: bus.iss_rs2, rd: bus.iss_rd,
                  q1: bus.iss_q1, q2: bus.iss_q2, has_rd: bus.iss_has_rd};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got packet %h, none expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL issue_pkt: got %h, expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 0; bus.in_inactive = 0; bus.in_mem = 0; bus.in_mul = 0; bus.in_lw_sw = 0;
    bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.rs_release_valid = 0; bus.rs_release_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0;

    // Reset state
    @(negedge clk);
    check("rst_iss_valid", 32'(bus.iss_valid), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst_iss_tag",   32'(bus.iss_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU add x3 <- x1,x2 then add x4 <- x3,x3 back-to-back
    expect_pkt(4'd1, 2'b00, 1'b0, 5'd1, 5'd2, 5'd3, 4'd0, 4'd0, 1'b1);
    send(0, 0, 0, 0, 5'd1, 5'd2, 5'd3);
    check("latency_e0", 32'(bus.iss_valid), 0);
    expect_pkt(4'd2, 2'b00, 1'b0, 5'd3, 5'd3, 5'd4, 4'd1, 4'd1, 1'b1);
    send(0, 0, 0, 0, 5'd3, 5'd3, 5'd4);
    check("latency_e1", 32'(bus.iss_valid), 1);
    idle();
    @(negedge clk);
    check("no_bubble_valid", 32'(bus.iss_valid), 1);
    check("no_bubble_tag",   32'(bus.iss_tag), 2);

    // Fill MUL, third mul stalls until tag 4 released
    expect_pkt(4'd4, 2'b01, 1'b0, 5'd1, 5'd2, 5'd6, 4'd0, 4'd0, 1'b1);
    send(0, 0, 1, 0, 5'd1, 5'd2, 5'd6);
    expect_pkt(4'd5, 2'b01, 1'b0, 5'd6, 5'd1, 5'd7, 4'd4, 4'd0, 1'b1);
    send(0, 0, 1, 0, 5'd6, 5'd1, 5'd7);
    expect_pkt(4'd4, 2'b01, 1'b0, 5'd1, 5'd1, 5'd8, 4'd0, 4'd0, 1'b1);
    send(0, 0, 1, 0, 5'd1, 5'd1, 5'd8);
    idle();
    repeat (3) @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 0);
    check("stall_cnt_3",    32'(bus.stall_cnt), 3);
    bus.rs_release_valid = 1'b1;
    bus.rs_release_tag   = 4'd4;
    @(negedge clk);
    bus.rs_release_valid = 1'b0;
    check("release_in_ready",  32'(bus.in_ready), 1);
    check("release_stall_cnt", 32'(bus.stall_cnt), 4);
    check("release_not_yet",   32'(bus.iss_valid), 0);
    @(negedge clk);
    check("post_issue_stall_cnt", 32'(bus.stall_cnt), 4);

    // CDB bypass: tag 1 broadcast on the issuing edge of add x5 <- x3,x4
    expect_pkt(4'd3, 2'b00, 1'b0, 5'd3, 5'd4, 5'd5, 4'd0, 4'd2, 1'b1);
    send(0, 0, 0, 0, 5'd3, 5'd4, 5'd5);
    idle();
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 4'd1;
    @(negedge clk);
    bus.cdb_valid = 1'b0;
    // RST[3] must now read 0; ALU full, so free tag 2 first
    bus.rs_release_valid = 1'b1;
    bus.rs_release_tag   = 4'd2;
    expect_pkt(4'd2, 2'b00, 1'b0, 5'd3, 5'd5, 5'd9, 4'd0, 4'd3, 1'b1);
    send(0, 0, 0, 0, 5'd3, 5'd5, 5'd9);
    bus.rs_release_valid = 1'b0;

    // Store (rd field 7, must not write RST) then load x0
    expect_pkt(4'd6, 2'b10, 1'b0, 5'd1, 5'd2, 5'd7, 4'd0, 4'd0, 1'b0);
    send(0, 1, 0, 0, 5'd1, 5'd2, 5'd7);
    expect_pkt(4'd7, 2'b10, 1'b1, 5'd5, 5'd4, 5'd0, 4'd3, 4'd0, 1'b0);
    send(0, 1, 0, 1, 5'd5, 5'd4, 5'd0);
    // RST[7] still holds the mul tag 5
    bus.rs_release_valid = 1'b1;
    bus.rs_release_tag   = 4'd1;
    expect_pkt(4'd1, 2'b00, 1'b0, 5'd7, 5'd0, 5'd10, 4'd5, 4'd0, 1'b1);
    send(0, 0, 0, 0, 5'd7, 5'd0, 5'd10);
    bus.rs_release_valid = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    check("queue_drained_1", 32'(exp_q.size()), 0);

    // Inactive instruction is dropped
    send(1, 0, 0, 0, 5'd1, 5'd2, 5'd11);
    idle();
    for (int i = 0; i < 3; i++) begin
      check("inactive_in_ready",  32'(bus.in_ready), 1);
      check("inactive_iss_valid", 32'(bus.iss_valid), 0);
      @(negedge clk);
    end

    // Reset while HELD (ALU full)
    send(0, 0, 0, 0, 5'd1, 5'd1, 5'd11);
    idle();
    @(negedge clk);
    check("held_in_ready",  32'(bus.in_ready), 0);
    check("held_stall_cnt", 32'(bus.stall_cnt), 5);
    rst_n = 1'b0;
    #1;
    check("rst2_iss_valid", 32'(bus.iss_valid), 0);
    check("rst2_iss_tag",   32'(bus.iss_tag), 0);
    check("rst2_iss_q1",    32'(bus.iss_q1), 0);
    check("rst2_iss_rd",    32'(bus.iss_rd), 0);
    check("rst2_has_rd",    32'(bus.iss_has_rd), 0);
    check("rst2_stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst2_in_ready",  32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // RST and busy cleared: fresh tag 1, no producers
    expect_pkt(4'd1, 2'b00, 1'b0, 5'd3, 5'd4, 5'd12, 4'd0, 4'd0, 1'b1);
    send(0, 0, 0, 0, 5'd3, 5'd4, 5'd12);
    idle();
    repeat (3) @(negedge clk);
    check("queue_drained_2", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time %0t exceeded", $time);
    $fatal(1, "timeout");
  end
endmodule
